crc16_frame_checker: RTL and testbench

Receive-side companion to the team's 16-bit-parallel CRC-16 generator: consumes a framed 16-bit word stream whose last word is a transmitted CRC, strips that word, forwards the payload unchanged and flags on the final payload word whether the CRC matched. Sits between the link deframer and the packet FIFO on the 16-bit datapath.

---
 rtl/crc16_frame_checker.sv | 174 +++++++++++++++++
 tb/tb_crc16_frame_checker.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/crc16_frame_checker.sv
// crc16_frame_checker
//   Receive-side CRC-16 checker for a framed 16-bit word stream. The last word
//   of each frame carries the transmitted CRC (poly x^16+x^12+x^5+1, MSB-first,
//   preset 16'hFFFF, no reflection, no final XOR). That word is stripped. The
//   payload is forwarded unchanged, and the final payload word carries o_err.
//   A one-word holding register delays the payload by one accepted word,
//   because the last payload word is only known once the CRC word arrives.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_data/i_sof/i_eof/i_src_rdy    upstream word and delimiters
//   i_dst_rdy                       checker can accept a word
//   o_data/o_sof/o_eof/o_err        payload word; o_err is valid with o_eof
//   o_src_rdy / o_dst_rdy           output handshake
//   frame_done                      one-cycle pulse per completed/aborted frame
//   crc_ok                          result of the last frame, held
//   frame_cnt, err_cnt              statistics (16-bit, wrapping)
//
// Configuration
//   CRC16_CHK_STATS_EN  defined: frame/error counters are built.
//                       undefined: frame_cnt/err_cnt are tied to zero.
module crc16_frame_checker (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_data,
  input  logic        i_sof,
  input  logic        i_eof,
  input  logic        i_src_rdy,
  output logic        i_dst_rdy,
  output logic [15:0] o_data,
  output logic        o_sof,
  output logic        o_eof,
  output logic        o_err,
  output logic        o_src_rdy,
  input  logic        o_dst_rdy,
  output logic        frame_done,
  output logic        crc_ok,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);

  localparam logic [15:0] INIT = 16'hFFFF;
  localparam logic [15:0] POLY = 16'h1021;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t      state_q, state_d;
  logic [15:0] held_q, held_d;
  logic        held_sof_q, held_sof_d;
  logic [15:0] crc_q, crc_d;
  logic        frame_done_q, frame_done_d;
  logic        crc_ok_q, crc_ok_d;
  logic [15:0] crc_calc;

  // One full 16-bit step of the serial LFSR, data bit 15 shifted in first.
  function automatic logic [15:0] crc_next(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int unsigned i = 0; i < 16; i++) begin
      fb = r[15] ^ d[15 - i];
      r  = {r[14:0], 1'b0} ^ ({16{fb}} & POLY);
    end
    return r;
  endfunction

  assign crc_calc = crc_next(crc_q, held_q);
  assign o_data   = held_q;

  always_comb begin
    state_d      = state_q;
    held_d       = held_q;
    held_sof_d   = held_sof_q;
    crc_d        = crc_q;
    frame_done_d = 1'b0;
    crc_ok_d     = crc_ok_q;
    i_dst_rdy    = 1'b0;
    o_src_rdy    = 1'b0;
    o_sof        = 1'b0;
    o_eof        = 1'b0;
    o_err        = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Ready is masked while reset is held so nothing looks accepted.
        i_dst_rdy = rst_n;
        if (i_src_rdy && i_sof) begin
          if (i_eof) begin
            // A runt frame has no room for payload plus CRC.
            frame_done_d = 1'b1;
            crc_ok_d     = 1'b0;
          end else begin
            held_d     = i_data;
            held_sof_d = 1'b1;
            crc_d      = INIT;
            state_d    = HOLD;
          end
        end
      end
      HOLD: begin
        o_src_rdy = i_src_rdy;
        i_dst_rdy = o_dst_rdy;
        o_sof     = held_sof_q;
        o_eof     = i_eof | i_sof;
        o_err     = i_sof | (i_eof & (crc_calc != i_data));
        if (i_src_rdy && o_dst_rdy) begin
          if (i_sof) begin
            // Abort: the held word closes the old frame with an error.
            frame_done_d = 1'b1;
            crc_ok_d     = 1'b0;
            if (i_eof) begin
              state_d = IDLE;
            end else begin
              held_d     = i_data;
              held_sof_d = 1'b1;
              crc_d      = INIT;
            end
          end else if (i_eof) begin
            frame_done_d = 1'b1;
            crc_ok_d     = ~o_err;
            state_d      = IDLE;
          end else begin
            crc_d      = crc_calc;
            held_d     = i_data;
            held_sof_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      held_q       <= '0;
      held_sof_q   <= 1'b0;
      crc_q        <= INIT;
      frame_done_q <= 1'b0;
      crc_ok_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      held_q       <= held_d;
      held_sof_q   <= held_sof_d;
      crc_q        <= crc_d;
      frame_done_q <= frame_done_d;
      crc_ok_q     <= crc_ok_d;
    end
  end

  assign frame_done = frame_done_q;
  assign crc_ok     = crc_ok_q;

`ifdef CRC16_CHK_STATS_EN
  logic [15:0] frame_cnt_q, err_cnt_q;

  // Counters step on the same edge that raises frame_done/crc_ok.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else if (frame_done_d) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
      if (!crc_ok_d) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`else
  assign frame_cnt = '0;
  assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_crc16_frame_checker.sv
module tb_crc16_frame_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] i_data;
  logic        i_sof, i_eof, i_src_rdy, i_dst_rdy;
  logic [15:0] o_data;
  logic        o_sof, o_eof, o_err, o_src_rdy, o_dst_rdy;
  logic        frame_done, crc_ok;
  logic [15:0] frame_cnt, err_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  crc16_frame_checker dut (
    .clk(clk), .rst_n(rst_n),
    .i_data(i_data), .i_sof(i_sof), .i_eof(i_eof),
    .i_src_rdy(i_src_rdy), .i_dst_rdy(i_dst_rdy),
    .o_data(o_data), .o_sof(o_sof), .o_eof(o_eof), .o_err(o_err),
    .o_src_rdy(o_src_rdy), .o_dst_rdy(o_dst_rdy),
    .frame_done(frame_done), .crc_ok(crc_ok),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  typedef struct {
    logic        sof, eof, src, dst;
    logic [15:0] data;
    logic        e_dst, e_src;
    logic [15:0] e_data;
    logic        e_sof, e_eof, e_err, e_done, e_ok;
  } vec_t;

  vec_t tbl[18];

  // Byte-wise golden CRC: high byte then low byte, 8 shifts per byte.
  function automatic logic [15:0] crc_word(input logic [15:0] c, input logic [15:0] w);
    logic [15:0] r;
    logic [7:0]  b;
    r = c;
    for (int n = 0; n < 2; n++) begin
      b = (n == 0) ? w[15:8] : w[7:0];
      r = r ^ {b, 8'h00};
      for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction

  function automatic vec_t mk(input logic sof, eof, src, dst, input logic [15:0] d,
                              input logic edst, esrc, input logic [15:0] ed,
                              input logic esof, eeof, eerr, edone, eok);
    vec_t v;
    v.sof = sof; v.eof = eof; v.src = src; v.dst = dst; v.data = d;
    v.e_dst = edst; v.e_src = esrc; v.e_data = ed;
    v.e_sof = esof; v.e_eof = eeof; v.e_err = eerr; v.e_done = edone; v.e_ok = eok;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic sof, eof, src, dst, input logic [15:0] d);
    i_sof = sof; i_eof = eof; i_src_rdy = src; o_dst_rdy = dst; i_data = d;
  endtask

  task automatic chk_counters(input string nm, input logic [15:0] f, input logic [15:0] e);
`ifdef CRC16_CHK_STATS_EN
    chk({nm, ".frame_cnt"}, 32'(frame_cnt), 32'(f));
    chk({nm, ".err_cnt"}, 32'(err_cnt), 32'(e));
`else
    chk({nm, ".frame_cnt"}, 32'(frame_cnt), 32'(f & 16'h0));
    chk({nm, ".err_cnt"}, 32'(err_cnt), 32'(e & 16'h0));
`endif
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [15:0] crc2, crcw, crc_c;
    logic [15:0] pay[8];
    int in_idx, outs, done_cnt;

    crc2 = crc_word(crc_word(16'hFFFF, 16'h1234), 16'h5678);
    //                sof eof src dst data      edst esrc edata    esof eeof eerr done ok
    tbl[0]  = mk(0, 0, 0, 1, 16'h0000,  1, 0, 16'h0000, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 1, 1, 16'h0000,  1, 0, 16'h0000, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 1, 1, 16'h1D0F,  1, 1, 16'h0000, 1, 1, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 1, 16'h0000,  1, 0, 16'h0000, 0, 0, 0, 1, 1);
    tbl[4]  = mk(1, 0, 1, 1, 16'h0000,  1, 0, 16'h0000, 0, 0, 0, 0, 1);
    tbl[5]  = mk(0, 1, 1, 1, 16'h1D0E,  1, 1, 16'h0000, 1, 1, 1, 0, 1);
    tbl[6]  = mk(0, 0, 0, 1, 16'h0000,  1, 0, 16'h0000, 0, 0, 0, 1, 0);
    tbl[7]  = mk(1, 0, 1, 1, 16'h1234,  1, 0, 16'h0000, 0, 0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 1, 0, 16'h5678,  0, 1, 16'h1234, 1, 0, 0, 0, 0);
    tbl[9]  = mk(0, 0, 1, 1, 16'h5678,  1, 1, 16'h1234, 1, 0, 0, 0, 0);
    tbl[10] = mk(0, 0, 0, 1, 16'h0000,  1, 0, 16'h0000, 0, 0, 0, 0, 0);
    tbl[11] = mk(0, 1, 1, 1, crc2,      1, 1, 16'h5678, 0, 1, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 1, 16'h0000,  1, 0, 16'h0000, 0, 0, 0, 1, 1);
    tbl[13] = mk(0, 0, 1, 1, 16'hAAAA,  1, 0, 16'h0000, 0, 0, 0, 0, 1);
    tbl[14] = mk(1, 1, 1, 1, 16'hBBBB,  1, 0, 16'h0000, 0, 0, 0, 0, 1);
    tbl[15] = mk(0, 0, 0, 1, 16'h0000,  1, 0, 16'h0000, 0, 0, 0, 1, 0);
    tbl[16] = mk(0, 1, 1, 1, 16'hCCCC,  1, 0, 16'h0000, 0, 0, 0, 0, 0);
    tbl[17] = mk(0, 0, 0, 1, 16'h0000,  1, 0, 16'h0000, 0, 0, 0, 0, 0);

    // Reset values
    rst_n = 1'b0;
    drive(0, 0, 0, 1, 16'h0000);
    #1;
    chk("rst.i_dst_rdy", 32'(i_dst_rdy), 0);
    chk("rst.o_src_rdy", 32'(o_src_rdy), 0);
    chk("rst.o_flags", {29'd0, o_sof, o_eof, o_err}, 0);
    chk("rst.o_data", 32'(o_data), 0);
    chk("rst.done_ok", {30'd0, frame_done, crc_ok}, 0);
    chk_counters("rst", 16'd0, 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: good, bad, backpressured 2-word frame, garbage and runt
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].sof, tbl[i].eof, tbl[i].src, tbl[i].dst, tbl[i].data);
      #1;
      chk($sformatf("v%0d.i_dst_rdy", i), 32'(i_dst_rdy), 32'(tbl[i].e_dst));
      chk($sformatf("v%0d.o_src_rdy", i), 32'(o_src_rdy), 32'(tbl[i].e_src));
      if (tbl[i].e_src) begin
        chk($sformatf("v%0d.o_data", i), 32'(o_data), 32'(tbl[i].e_data));
        chk($sformatf("v%0d.o_sof", i), 32'(o_sof), 32'(tbl[i].e_sof));
        chk($sformatf("v%0d.o_eof", i), 32'(o_eof), 32'(tbl[i].e_eof));
        chk($sformatf("v%0d.o_err", i), 32'(o_err), 32'(tbl[i].e_err));
      end
      chk($sformatf("v%0d.frame_done", i), 32'(frame_done), 32'(tbl[i].e_done));
      chk($sformatf("v%0d.crc_ok", i), 32'(crc_ok), 32'(tbl[i].e_ok));
      tick();
    end
    chk_counters("tbl", 16'd4, 16'd2);

    // Multi-word frame with random handshake gaps
    for (int k = 0; k < 8; k++) pay[k] = 16'($urandom);
    crcw = 16'hFFFF;
    for (int k = 0; k < 8; k++) crcw = crc_word(crcw, pay[k]);
    in_idx = 0; outs = 0; done_cnt = 0;
    for (int cyc = 0; cyc < 400 && in_idx < 9; cyc++) begin
      drive(in_idx == 0, in_idx == 8, $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0, (in_idx < 8) ? pay[in_idx] : crcw);
      #1;
      if (frame_done) done_cnt++;
      if (o_src_rdy && o_dst_rdy) begin
        if (outs < 8) begin
          chk($sformatf("rnd.data%0d", outs), 32'(o_data), 32'(pay[outs]));
          chk($sformatf("rnd.sof%0d", outs), 32'(o_sof), 32'(outs == 0));
          chk($sformatf("rnd.eof%0d", outs), 32'(o_eof), 32'(outs == 7));
          if (outs == 7) chk("rnd.err", 32'(o_err), 0);
        end
        outs++;
      end
      if (i_src_rdy && i_dst_rdy) in_idx++;
      tick();
    end
    drive(0, 0, 0, 1, 16'h0000);
    #1;
    if (frame_done) done_cnt++;
    chk("rnd.words_in", 32'(in_idx), 9);
    chk("rnd.words_out", 32'(outs), 8);
    chk("rnd.done_cnt", 32'(done_cnt), 1);
    chk("rnd.crc_ok", 32'(crc_ok), 1);
    tick();
    #1;
    chk("rnd.done_pulse_end", 32'(frame_done), 0);
    chk_counters("rnd", 16'd5, 16'd2);

    // Abort: sof A, B, sof C, D = CRC(C)
    crc_c = crc_word(16'hFFFF, 16'h3333);
    drive(1, 0, 1, 1, 16'h1111); tick();
    drive(0, 0, 1, 1, 16'h2222);
    #1;
    chk("abt.A", {o_data, 13'd0, o_sof, o_eof, o_err}, {16'h1111, 16'h0004});
    tick();
    drive(1, 0, 1, 1, 16'h3333);
    #1;
    chk("abt.B", {o_data, 13'd0, o_sof, o_eof, o_err}, {16'h2222, 16'h0003});
    chk("abt.B_src_rdy", 32'(o_src_rdy), 1);
    tick();
    drive(0, 1, 1, 1, crc_c);
    #1;
    chk("abt.C", {o_data, 13'd0, o_sof, o_eof, o_err}, {16'h3333, 16'h0006});
    chk("abt.done1", {30'd0, frame_done, crc_ok}, 32'h2);
    tick();
    drive(0, 0, 0, 1, 16'h0000);
    #1;
    chk("abt.done2", {30'd0, frame_done, crc_ok}, 32'h3);
    tick();
    chk_counters("abt", 16'd7, 16'd3);

    // Reset mid-frame
    drive(1, 0, 1, 1, 16'h4444); tick();
    drive(0, 0, 1, 1, 16'h5555);
    #1;
    chk("mrst.pre_src_rdy", 32'(o_src_rdy), 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mrst.i_dst_rdy", 32'(i_dst_rdy), 0);
    chk("mrst.o_src_rdy", 32'(o_src_rdy), 0);
    chk("mrst.o_flags", {29'd0, o_sof, o_eof, o_err}, 0);
    chk("mrst.o_data", 32'(o_data), 0);
    chk("mrst.done_ok", {30'd0, frame_done, crc_ok}, 0);
    chk_counters("mrst", 16'd0, 16'd0);
    tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 1, 16'h0000);
    tick();
    drive(1, 0, 1, 1, 16'h0000); tick();
    drive(0, 1, 1, 1, 16'h1D0F);
    #1;
    chk("post.word", {o_data, 12'd0, o_src_rdy, o_sof, o_eof, o_err}, {16'h0000, 16'h000E});
    tick();
    drive(0, 0, 0, 1, 16'h0000);
    #1;
    chk("post.done_ok", {30'd0, frame_done, crc_ok}, 32'h3);
    chk_counters("post", 16'd1, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
